// File: rtl/sdram_probe_pkg.sv
// sdram_probe_pkg: shared state encodings and probe address/signature
// helpers for the SDRAM size-detection engine.
package sdram_probe_pkg;

   // Largest supported number of probe points (the probe index is 3 bits).
   localparam int unsigned MAX_PROBES = 8;

   // Engine phases.
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_WR    = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RD    = 3'd3,
      ST_CLEAR = 3'd4,
      ST_IDLE  = 3'd5
   } state_t;

   // Per-transaction sub-phase: strobe cycle, blind cycle, wait-for-ready.
   typedef enum logic [1:0] {
      PH_ISSUE = 2'd0,
      PH_GAP   = 2'd1,
      PH_WAIT  = 2'd2
   } phase_t;

   // Probe address: 0 for probe 0, otherwise one address bit per probe.
   function automatic logic [63:0] probe_addr(input logic [31:0] k,
                                              input logic [31:0] base_bit);
      logic [63:0] a;
      if (k == 32'd0) begin
         a = 64'd0;
      end else begin
         a = 64'd1 << (base_bit + k - 32'd1);
      end
      return a;
   endfunction

   // Signature written to probe k (caller truncates to the data width).
   function automatic logic [31:0] probe_sig(input logic [31:0] k,
                                             input logic [31:0] sig_base,
                                             input logic [31:0] sig_step);
      return sig_base + (k * sig_step);
   endfunction

   // Address used to put a non-signature value on the bus before readback.
   function automatic logic [63:0] flush_addr(input logic [31:0] base_bit);
      logic [63:0] a;
      if (base_bit == 32'd0) begin
         a = 64'd1;
      end else begin
         a = 64'd1 << (base_bit - 32'd1);
      end
      return a;
   endfunction

endpackage

// File: rtl/sdram_probe.sv
// sdram_probe: after controller init, writes signatures at power-of-two
// addresses, reads them back to find which address bits hold real memory,
// then optionally zero-fills the start of RAM.
// Optional feature macro: SDRAM_PROBE_CLEAR_EN (enables the CLEAR phase).
module sdram_probe
   import sdram_probe_pkg::*;
#(
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned PROBES      = 3,
   parameter int unsigned BASE_BIT    = 25,
   parameter int unsigned SIG_BASE    = 1032,
   parameter int unsigned SIG_STEP    = 1032,
   parameter int unsigned FLUSH_VAL   = 12345,
   parameter int unsigned CLEAR_WORDS = 2**24
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              rerun,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              mem_rd,
   output logic [PROBES-1:0] size_mask,
   output logic              probe_done,
   output logic              clear_busy
);

   if ((PROBES < 1) || (PROBES > MAX_PROBES)) begin : g_bad_probes
      $error("sdram_probe: PROBES must be in 1..8");
   end
   if (CLEAR_WORDS < 1) begin : g_bad_clear
      $error("sdram_probe: CLEAR_WORDS must be at least 1");
   end

   state_t              r_state, w_state_nx;
   phase_t              r_phase, w_phase_nx;
   logic [2:0]          r_k, w_k_nx;
   logic [ADDR_W-1:0]   r_addr, w_addr_nx;
   logic [DATA_W-1:0]   r_din, w_din_nx;
   logic                r_we, w_we_nx;
   logic                r_rd, w_rd_nx;
   logic [PROBES-1:0]   r_mask, w_mask_nx;
   logic                r_done, w_done_nx;
   logic                r_pend, w_pend_nx;
`ifdef SDRAM_PROBE_CLEAR_EN
   logic                r_busy, w_busy_nx;
`endif

   logic                w_xdone;
   logic                w_go;
   logic [2:0]          w_k_dec;
   logic [2:0]          w_k_top;

   // A transaction ends on the first ready cycle of its WAIT phase.
   assign w_xdone = (r_phase == PH_WAIT) && mem_ready;
   assign w_go    = rerun || r_pend;
   assign w_k_dec = r_k - 3'd1;
   assign w_k_top = 3'(PROBES - 1);

   // Next-state, next-output computation for the probe/clear sequencer.
   always_comb begin
      w_state_nx = r_state;
      w_phase_nx = r_phase;
      w_k_nx     = r_k;
      w_addr_nx  = r_addr;
      w_din_nx   = r_din;
      w_we_nx    = 1'b0;
      w_rd_nx    = 1'b0;
      w_mask_nx  = r_mask;
      w_done_nx  = r_done;
`ifdef SDRAM_PROBE_CLEAR_EN
      w_busy_nx  = r_busy;
`endif
      // A rerun seen while clearing or idle is remembered until it can act.
      if (rerun && ((r_state == ST_IDLE) || (r_state == ST_CLEAR))) begin
         w_pend_nx = 1'b1;
      end else begin
         w_pend_nx = r_pend;
      end

      case (r_phase)
         PH_ISSUE: w_phase_nx = PH_GAP;
         PH_GAP:   w_phase_nx = PH_WAIT;
         default:  w_phase_nx = r_phase;
      endcase

      case (r_state)
         ST_INIT: begin
            w_mask_nx = '0;
            w_done_nx = 1'b0;
            w_pend_nx = 1'b0;
`ifdef SDRAM_PROBE_CLEAR_EN
            w_busy_nx = 1'b0;
`endif
            if (mem_ready) begin
               w_state_nx = ST_WR;
               w_phase_nx = PH_ISSUE;
               w_k_nx     = w_k_top;
               w_addr_nx  = ADDR_W'(probe_addr({29'd0, w_k_top}, 32'(BASE_BIT)));
               w_din_nx   = DATA_W'(probe_sig({29'd0, w_k_top}, 32'(SIG_BASE), 32'(SIG_STEP)));
               w_we_nx    = 1'b1;
            end else begin
               w_state_nx = ST_INIT;
            end
         end

         ST_WR: begin
            if (w_xdone && (r_k == 3'd0)) begin
               w_state_nx = ST_FLUSH;
               w_phase_nx = PH_ISSUE;
               w_addr_nx  = ADDR_W'(flush_addr(32'(BASE_BIT)));
               w_din_nx   = DATA_W'(FLUSH_VAL);
               w_we_nx    = 1'b1;
            end else if (w_xdone) begin
               w_phase_nx = PH_ISSUE;
               w_k_nx     = w_k_dec;
               w_addr_nx  = ADDR_W'(probe_addr({29'd0, w_k_dec}, 32'(BASE_BIT)));
               w_din_nx   = DATA_W'(probe_sig({29'd0, w_k_dec}, 32'(SIG_BASE), 32'(SIG_STEP)));
               w_we_nx    = 1'b1;
            end else begin
               w_state_nx = ST_WR;
            end
         end

         ST_FLUSH: begin
            if (w_xdone) begin
               w_state_nx = ST_RD;
               w_phase_nx = PH_ISSUE;
               w_k_nx     = w_k_top;
               w_addr_nx  = ADDR_W'(probe_addr({29'd0, w_k_top}, 32'(BASE_BIT)));
               w_rd_nx    = 1'b1;
            end else begin
               w_state_nx = ST_FLUSH;
            end
         end

         ST_RD: begin
            if (w_xdone) begin
               for (int i = 0; i < int'(PROBES); i++) begin
                  if (r_k == 3'(i)) begin
                     w_mask_nx[i] = (mem_dout ==
                        DATA_W'(probe_sig(32'(i), 32'(SIG_BASE), 32'(SIG_STEP))));
                  end else begin
                     w_mask_nx[i] = r_mask[i];
                  end
               end
               if (r_k == 3'd0) begin
                  w_done_nx = 1'b1;
`ifdef SDRAM_PROBE_CLEAR_EN
                  w_state_nx = ST_CLEAR;
                  w_phase_nx = PH_ISSUE;
                  w_busy_nx  = 1'b1;
                  w_addr_nx  = '0;
                  w_din_nx   = '0;
                  w_we_nx    = 1'b1;
`else
                  w_state_nx = ST_IDLE;
`endif
               end else begin
                  w_phase_nx = PH_ISSUE;
                  w_k_nx     = w_k_dec;
                  w_addr_nx  = ADDR_W'(probe_addr({29'd0, w_k_dec}, 32'(BASE_BIT)));
                  w_rd_nx    = 1'b1;
               end
            end else begin
               w_state_nx = ST_RD;
            end
         end

`ifdef SDRAM_PROBE_CLEAR_EN
         ST_CLEAR: begin
            // The clear address doubles as the word counter.
            if (w_xdone && w_go) begin
               w_state_nx = ST_INIT;
               w_pend_nx  = 1'b0;
               w_busy_nx  = 1'b0;
               w_mask_nx  = '0;
               w_done_nx  = 1'b0;
            end else if (w_xdone && (r_addr == ADDR_W'(CLEAR_WORDS - 1))) begin
               w_state_nx = ST_IDLE;
               w_busy_nx  = 1'b0;
            end else if (w_xdone) begin
               w_phase_nx = PH_ISSUE;
               w_addr_nx  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               w_we_nx    = 1'b1;
            end else begin
               w_state_nx = ST_CLEAR;
            end
         end
`endif

         ST_IDLE: begin
            if (w_go) begin
               w_state_nx = ST_INIT;
               w_pend_nx  = 1'b0;
               w_mask_nx  = '0;
               w_done_nx  = 1'b0;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end

         default: begin
            w_state_nx = ST_INIT;
         end
      endcase
   end

   // State and registered-output update; async reset drops everything at once.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_INIT;
         r_phase <= PH_ISSUE;
         r_k     <= 3'd0;
         r_addr  <= '0;
         r_din   <= '0;
         r_we    <= 1'b0;
         r_rd    <= 1'b0;
         r_mask  <= '0;
         r_done  <= 1'b0;
         r_pend  <= 1'b0;
`ifdef SDRAM_PROBE_CLEAR_EN
         r_busy  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_phase <= w_phase_nx;
         r_k     <= w_k_nx;
         r_addr  <= w_addr_nx;
         r_din   <= w_din_nx;
         r_we    <= w_we_nx;
         r_rd    <= w_rd_nx;
         r_mask  <= w_mask_nx;
         r_done  <= w_done_nx;
         r_pend  <= w_pend_nx;
`ifdef SDRAM_PROBE_CLEAR_EN
         r_busy  <= w_busy_nx;
`endif
      end
   end

   assign mem_addr   = r_addr;
   assign mem_din    = r_din;
   assign mem_we     = r_we;
   assign mem_rd     = r_rd;
   assign size_mask  = r_mask;
   assign probe_done = r_done;
`ifdef SDRAM_PROBE_CLEAR_EN
   assign clear_busy = r_busy;
`else
   assign clear_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_probe.sv
// tb_sdram_probe: table-driven check of sdram_probe against a small SDRAM
// model with configurable address aliasing, stuck data and ready stalls.
`timescale 1ns/1ps
module tb_sdram_probe;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        rerun;
   logic        mem_ready;
   logic [15:0] mem_dout = 16'd0;
   logic [26:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic        mem_rd;
   logic [2:0]  size_mask;
   logic        probe_done;
   logic        clear_busy;

   sdram_probe #(.CLEAR_WORDS(16)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .rerun      (rerun),
      .mem_ready  (mem_ready),
      .mem_dout   (mem_dout),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd),
      .size_mask  (size_mask),
      .probe_done (probe_done),
      .clear_busy (clear_busy)
   );

   always #5 clk_sys = ~clk_sys;

   // ---------------- SDRAM model ----------------
   logic [26:0] m_amask = 27'h7FFFFFF;
   bit          m_stuck = 1'b0;
   int          m_stall = 0;
   int          m_cnt   = 0;
   logic [15:0] m_mem [128];

   function automatic logic [6:0] mkey(input logic [26:0] a);
      return {a[26:24], a[3:0]};
   endfunction

   // Model: writes/reads on strobe, ready low for m_stall cycles afterwards.
   always @(posedge clk_sys) begin
      if (mem_we) m_mem[mkey(mem_addr & m_amask)] <= mem_din;
      if (mem_rd) mem_dout <= m_stuck ? 16'd0 : m_mem[mkey(mem_addr & m_amask)];
      if (mem_we || mem_rd) m_cnt <= m_stall;
      else if (m_cnt != 0) m_cnt <= m_cnt - 1;
   end
   assign mem_ready = (m_cnt == 0);

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        is_wr;
      logic [26:0] addr;
      logic [15:0] din;
   } txn_t;
   txn_t exp_q[$];

   typedef struct {
      string       name;
      logic [26:0] amask;
      bit          stuck;
      int          stall;
      logic [2:0]  exp_mask;
   } vec_t;
   vec_t vecs[5];

   int  n_checks = 0;
   int  n_errors = 0;
   bit  prev_strobe = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [63:0] outs();
      return {14'd0, size_mask, probe_done, clear_busy, mem_we, mem_rd, mem_addr, mem_din};
   endfunction

   task automatic push_txn(input logic w, input logic [26:0] a, input logic [15:0] d);
      txn_t t;
      t.is_wr = w; t.addr = a; t.din = d;
      exp_q.push_back(t);
   endtask

   task automatic push_all();
      push_txn(1'b1, 27'h4000000, 16'd3096);
      push_txn(1'b1, 27'h2000000, 16'd2064);
      push_txn(1'b1, 27'h0000000, 16'd1032);
      push_txn(1'b1, 27'h1000000, 16'd12345);
      push_txn(1'b0, 27'h4000000, 16'd0);
      push_txn(1'b0, 27'h2000000, 16'd0);
      push_txn(1'b0, 27'h0000000, 16'd0);
`ifdef SDRAM_PROBE_CLEAR_EN
      for (int i = 0; i < 16; i++) push_txn(1'b1, 27'(i), 16'd0);
`endif
   endtask

   // One cycle: sample at the falling edge and score any strobe seen.
   task automatic step();
      txn_t e;
      bit   strobe;
      @(negedge clk_sys);
      strobe = mem_we || mem_rd;
      if (strobe) begin
         n_checks++;
         if (mem_we && mem_rd) begin
            n_errors++;
            $display("FAIL strobe_overlap: we=%0b rd=%0b, expected one strobe", mem_we, mem_rd);
         end else if (prev_strobe) begin
            n_errors++;
            $display("FAIL strobe_width: strobe high two cycles in a row at addr %h", mem_addr);
         end else if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL txn_unexpected: got we=%0b addr=%h din=%0d, expected no transaction",
                     mem_we, mem_addr, mem_din);
         end else begin
            e = exp_q.pop_front();
            if ((e.is_wr != mem_we) || (e.addr != mem_addr) || (e.is_wr && (e.din != mem_din))) begin
               n_errors++;
               $display("FAIL txn: got we=%0b addr=%h din=%0d, expected we=%0b addr=%h din=%0d",
                        mem_we, mem_addr, mem_din, e.is_wr, e.addr, e.din);
            end
         end
      end
      prev_strobe = strobe;
   endtask

   task automatic do_reset(input logic [26:0] amask, input bit stuck, input int stall);
      @(negedge clk_sys);
      reset_n = 1'b0;
      rerun   = 1'b0;
      m_amask = amask;
      m_stuck = stuck;
      m_stall = stall;
      step();
      step();
      check("reset_outputs", outs(), 64'd0);
      exp_q.delete();
      prev_strobe = 1'b0;
      push_all();
      reset_n = 1'b1;
   endtask

   task automatic run_to_done(input string name, input logic [2:0] exp_mask, input bit chk_lat);
      int t;
      int first;
      t = 0;
      first = -1;
      while ((probe_done !== 1'b1) && (t < 4000)) begin
         step();
         t++;
         if ((first < 0) && (mem_we || mem_rd)) first = t;
      end
      check({name, "_probe_done"}, 64'(probe_done), 64'd1);
      check({name, "_mask"}, 64'(size_mask), 64'(exp_mask));
      if (chk_lat) check({name, "_latency"}, 64'(t - first), 64'd21);
`ifdef SDRAM_PROBE_CLEAR_EN
      check({name, "_busy_at_done"}, 64'(clear_busy), 64'd1);
`else
      check({name, "_busy_at_done"}, 64'(clear_busy), 64'd0);
`endif
      t = 0;
      while (((clear_busy !== 1'b0) || (exp_q.size() != 0)) && (t < 4000)) begin
         step();
         t++;
      end
      check({name, "_busy_end"}, 64'(clear_busy), 64'd0);
      check({name, "_txn_left"}, 64'(exp_q.size()), 64'd0);
      repeat (4) step();
      check({name, "_mask_hold"}, 64'(size_mask), 64'(exp_mask));
      check({name, "_done_hold"}, 64'(probe_done), 64'd1);
   endtask

   initial begin
      int  t;
      bit  found;
      reset_n = 1'b0;
      rerun   = 1'b0;

      vecs[0] = '{"full",      27'h7FFFFFF, 1'b0, 0, 3'b111};
      vecs[1] = '{"alias_ge25", 27'h1FFFFFF, 1'b0, 0, 3'b001};
      vecs[2] = '{"alias_b26", 27'h3FFFFFF, 1'b0, 0, 3'b011};
      vecs[3] = '{"stuck0",    27'h7FFFFFF, 1'b1, 0, 3'b000};
      vecs[4] = '{"full_stall3", 27'h7FFFFFF, 1'b0, 3, 3'b111};

      for (int v = 0; v < 5; v++) begin
         do_reset(vecs[v].amask, vecs[v].stuck, vecs[v].stall);
         run_to_done(vecs[v].name, vecs[v].exp_mask, vecs[v].stall == 0);
      end

      // Reset pulse while reading probe 1, then a complete fresh run.
      do_reset(27'h7FFFFFF, 1'b0, 0);
      found = 1'b0;
      t = 0;
      while (!found && (t < 400)) begin
         step();
         t++;
         if (mem_rd && (mem_addr == 27'h2000000)) found = 1'b1;
      end
      check("rstrd_reached", 64'(found), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rstrd_async_clear", outs(), 64'd0);
      step();
      step();
      check("rstrd_held_clear", outs(), 64'd0);
      exp_q.delete();
      prev_strobe = 1'b0;
      push_all();
      reset_n = 1'b1;
      run_to_done("rstrd_rerun", 3'b111, 1'b1);

      // Slow controller; rerun during a clear WAIT (or in IDLE without clear).
      do_reset(27'h7FFFFFF, 1'b0, 10);
      t = 0;
      while ((probe_done !== 1'b1) && (t < 4000)) begin
         step();
         t++;
      end
      check("stall_mask", 64'(size_mask), 64'd7);
`ifdef SDRAM_PROBE_CLEAR_EN
      found = 1'b0;
      t = 0;
      while (!found && (t < 4000)) begin
         step();
         t++;
         if (mem_we && (mem_addr == 27'd2)) found = 1'b1;
      end
      check("stall_clear_reached", 64'(found), 64'd1);
      repeat (4) step();
      check("stall_busy_before", 64'(clear_busy), 64'd1);
`else
      t = 0;
      while ((exp_q.size() != 0) && (t < 4000)) begin
         step();
         t++;
      end
      repeat (3) step();
`endif
      @(negedge clk_sys);
      rerun = 1'b1;
      step();
      rerun = 1'b0;
`ifdef SDRAM_PROBE_CLEAR_EN
      check("stall_wait_completes", 64'({probe_done, clear_busy}), 64'd3);
`endif
      exp_q.delete();
      push_all();
      t = 0;
      while ((probe_done !== 1'b0) && (t < 40)) begin
         step();
         t++;
      end
      check("stall_reinit", 64'({size_mask, probe_done, clear_busy}), 64'd0);
      run_to_done("stall_rerun", 3'b111, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
